// File: rtl/io_spi_master_if.sv
// rtl/io_spi_master_if.sv - CPU IO-cycle bus between light8080 core and SPI master peripheral
interface io_spi_master_if;
    logic [7:0] cpu_addr;
    logic       cpu_io;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_dout;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       irq;

    modport master (
        output cpu_addr, cpu_io, cpu_rd, cpu_wr, cpu_dout,
        input  rd_data, rd_valid, irq
    );

    modport slave (
        input  cpu_addr, cpu_io, cpu_rd, cpu_wr, cpu_dout,
        output rd_data, rd_valid, irq
    );
endinterface

// File: rtl/io_spi_master.sv
// rtl/io_spi_master.sv - IO-mapped mode-0 MSB-first SPI master with DATA/STAT/CTRL registers
module io_spi_master #(
    parameter logic [7:0] BASE = 8'h90
) (
    input  logic             clock,
    input  logic             reset,
    io_spi_master_if.slave   bus,
    output logic             spi_sck,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_ss_n
);
    localparam logic [7:0] STAT_ADDR = BASE + 8'd1;
    localparam logic [7:0] CTRL_ADDR = BASE + 8'd2;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state_q;
    logic [7:0] ctrl_q;
    logic [7:0] shreg_q;
    logic [7:0] rx_byte_q;
    logic [7:0] rd_data_q;
    logic       rd_valid_q;
    logic       rx_full_q;
    logic       ovr_q;
    logic       sck_q;
    logic       mosi_q;
    logic       rx_bit_q;
    logic [6:0] cnt_q;
    logic [6:0] lim_q;
    logic [3:0] tog_q;

    logic       busy;
    logic       wr_data_hit;
    logic       wr_ctrl_hit;
    logic       rd_data_hit;
    logic       rd_stat_hit;
    logic       rd_ctrl_hit;
    logic       rd_hit;
    logic [6:0] lim_d;
    logic [7:0] rd_data_d;

    assign busy        = (state_q == SHIFT);
    assign wr_data_hit = bus.cpu_io & bus.cpu_wr & (bus.cpu_addr == BASE);
    assign wr_ctrl_hit = bus.cpu_io & bus.cpu_wr & (bus.cpu_addr == CTRL_ADDR);
    assign rd_data_hit = bus.cpu_io & bus.cpu_rd & (bus.cpu_addr == BASE);
    assign rd_stat_hit = bus.cpu_io & bus.cpu_rd & (bus.cpu_addr == STAT_ADDR);
    assign rd_ctrl_hit = bus.cpu_io & bus.cpu_rd & (bus.cpu_addr == CTRL_ADDR);
    assign rd_hit      = rd_data_hit | rd_stat_hit | rd_ctrl_hit;

    // Terminal count of the half-period counter: 2^div - 1, resampled at every toggle
    // so a CTRL write only affects half periods that start after it.
    assign lim_d = 7'h7f >> (3'd7 - ctrl_q[2:0]);

    // Read-back mux; sampled into rd_data_q only on a read hit.
    always_comb begin
        rd_data_d = ctrl_q;
        if (rd_data_hit) begin
            rd_data_d = rx_byte_q;
        end else if (rd_stat_hit) begin
            rd_data_d = {5'b0, ovr_q, rx_full_q, busy};
        end
    end

    // Register file, read port and the IDLE/SHIFT transfer engine.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= 8'h83;
            shreg_q    <= 8'h00;
            rx_byte_q  <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            rx_full_q  <= 1'b0;
            ovr_q      <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            rx_bit_q   <= 1'b0;
            cnt_q      <= 7'd0;
            lim_q      <= 7'd0;
            tog_q      <= 4'd0;
        end else begin
            rd_valid_q <= rd_hit;
            if (rd_hit) begin
                rd_data_q <= rd_data_d;
            end
            if (wr_ctrl_hit) begin
                ctrl_q <= bus.cpu_dout;
            end
            // A dropped write wins over a simultaneous STAT read clearing ovr.
            if (wr_data_hit && busy) begin
                ovr_q <= 1'b1;
            end else if (rd_stat_hit) begin
                ovr_q <= 1'b0;
            end
            // Cleared by a DATA read; a completing transfer below overrides this.
            if (rd_data_hit) begin
                rx_full_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (wr_data_hit) begin
                        shreg_q <= bus.cpu_dout;
                        mosi_q  <= bus.cpu_dout[7];
                        cnt_q   <= 7'd0;
                        lim_q   <= lim_d;
                        tog_q   <= 4'd0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q == lim_q) begin
                        cnt_q <= 7'd0;
                        lim_q <= lim_d;
                        sck_q <= ~sck_q;
                        tog_q <= tog_q + 4'd1;
                        if (!sck_q) begin
                            rx_bit_q <= spi_miso;
                        end else begin
                            shreg_q <= {shreg_q[6:0], rx_bit_q};
                            mosi_q  <= shreg_q[6];
                            if (tog_q == 4'd15) begin
                                rx_byte_q <= {shreg_q[6:0], rx_bit_q};
                                rx_full_q <= 1'b1;
                                state_q   <= IDLE;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.irq      = rx_full_q & ctrl_q[6];
    assign spi_sck      = sck_q;
    assign spi_mosi     = mosi_q;
    assign spi_ss_n     = ctrl_q[7];
endmodule
